// File: rtl/leaf_tx_scheduler.sv
// leaf_tx_scheduler
// Round-robin arbiter that shares one BFT leaf output port between three
// local requesters. It owns the registered leaf packet, replays the in-flight
// packet while the leaf asserts resend, and drops it once the replay budget
// (MAX_RESEND extra cycles) is used up.
//
// Optional build macro: LEAF_TX_STATS_EN
//   When defined, two saturating statistics outputs are added:
//   resend_total (cycles with resend while busy) and drop_total (drops).
module leaf_tx_scheduler #(
  parameter int PAYLOAD_W  = 48,
  parameter int MAX_RESEND = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [2:0]               req_valid,
  input  logic [3*PAYLOAD_W-1:0]   req_data,
  output logic [2:0]               req_ready,
  input  logic                     resend,
  output logic [PAYLOAD_W:0]       dout_leaf_interface2bft,
  output logic [1:0]               grant_id,
  output logic                     drop_err,
  output logic                     busy
`ifdef LEAF_TX_STATS_EN
  ,
  output logic [15:0]              resend_total,
  output logic [7:0]               drop_total
`endif
);

  localparam int RETRY_W = $clog2(MAX_RESEND + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SENT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [PAYLOAD_W:0]   dout_n;
  logic [1:0]           grant_n;
  logic [1:0]           rr_ptr;
  logic [1:0]           rr_n;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [RETRY_W-1:0]   retry_n;
  logic                 drop_n;

  logic                 win_found;
  logic [1:0]           win_idx;
  logic [1:0]           cand;
  logic                 accept;
  logic [PAYLOAD_W-1:0] win_data;

  assign busy = dout_leaf_interface2bft[PAYLOAD_W];

  // Pick the first valid requester after the last one granted, wrapping mod 3
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(rr_ptr) + k) % 3);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Ready goes to the winner only; resend blocks new traffic, which also
  // covers the cycle in which a held packet is being dropped
  always_comb begin
    req_ready = 3'b000;
    accept    = 1'b0;
    win_data  = req_data[win_idx*PAYLOAD_W +: PAYLOAD_W];
    if (ap_start && !resend && win_found) begin
      req_ready = 3'b001 << win_idx;
      accept    = 1'b1;
    end
  end

  // Next-state and next-output logic for the send/replay/drop sequence
  always_comb begin
    state_n = state;
    dout_n  = dout_leaf_interface2bft;
    grant_n = grant_id;
    rr_n    = rr_ptr;
    retry_n = retry_cnt;
    drop_n  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          dout_n  = {1'b1, win_data};
          grant_n = win_idx;
          rr_n    = win_idx;
          retry_n = '0;
          state_n = SENT;
        end
      end
      SENT, HOLD: begin
        if (!resend) begin
          if (accept) begin
            dout_n  = {1'b1, win_data};
            grant_n = win_idx;
            rr_n    = win_idx;
            retry_n = '0;
            state_n = SENT;
          end else begin
            dout_n  = '0;
            retry_n = '0;
            state_n = IDLE;
          end
        end else if (retry_cnt < RETRY_W'(MAX_RESEND)) begin
          retry_n = retry_cnt + RETRY_W'(1);
          state_n = HOLD;
        end else begin
          dout_n  = '0;
          drop_n  = 1'b1;
          retry_n = '0;
          state_n = IDLE;
        end
      end
      default: begin
        dout_n  = '0;
        retry_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered leaf outputs; reset discards any in-flight packet
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      dout_leaf_interface2bft <= '0;
      grant_id                <= 2'd0;
      rr_ptr                  <= 2'd2;
      retry_cnt               <= '0;
      drop_err                <= 1'b0;
    end else begin
      state                   <= state_n;
      dout_leaf_interface2bft <= dout_n;
      grant_id                <= grant_n;
      rr_ptr                  <= rr_n;
      retry_cnt               <= retry_n;
      drop_err                <= drop_n;
    end
  end

`ifdef LEAF_TX_STATS_EN
  // Saturating counters of back-pressured cycles and dropped packets
  always_ff @(posedge clk) begin
    if (reset) begin
      resend_total <= '0;
      drop_total   <= '0;
    end else begin
      if (resend && busy && (resend_total != 16'hFFFF)) begin
        resend_total <= resend_total + 16'd1;
      end
      if (drop_n && (drop_total != 8'hFF)) begin
        drop_total <= drop_total + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_tx_scheduler.sv
// tb_leaf_tx_scheduler
// Directed scenarios plus a randomized run against a transaction-level model
// of the leaf scheduler. Stats checks compile in when LEAF_TX_STATS_EN is set.
module tb_leaf_tx_scheduler;

  localparam int PW   = 48;
  localparam int MAXR = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            ap_start;
  logic            resend;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*PW-1:0] req_data;
  logic [PW:0]     dout;
  logic [1:0]      grant_id;
  logic            drop_err;
  logic            busy;
`ifdef LEAF_TX_STATS_EN
  logic [15:0]     resend_total;
  logic [7:0]      drop_total;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last granted requester, in-flight packet and how long it has been on the wire
  int          m_last;
  logic        m_busy;
  logic [PW-1:0] m_data;
  logic [1:0]  m_id;
  int          m_wire;
  logic        m_drop;
  int          m_rt;
  int          m_dt;

  always #5 clk = ~clk;

  leaf_tx_scheduler #(.PAYLOAD_W(PW), .MAX_RESEND(MAXR)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .ap_start                (ap_start),
    .req_valid               (req_valid),
    .req_data                (req_data),
    .req_ready               (req_ready),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout),
    .grant_id                (grant_id),
    .drop_err                (drop_err),
    .busy                    (busy)
`ifdef LEAF_TX_STATS_EN
    ,
    .resend_total            (resend_total),
    .drop_total              (drop_total)
`endif
  );

  function automatic logic [PW-1:0] rand_payload();
    return PW'({$urandom(), $urandom()});
  endfunction

  function automatic int model_winner();
    for (int k = 1; k <= 3; k++) begin
      if (req_valid[(m_last + k) % 3]) return (m_last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_ready();
    int w;
    w = model_winner();
    if (ap_start && !resend && w >= 0) return 3'(1 << w);
    return 3'b000;
  endfunction

  function automatic logic [PW:0] model_dout();
    return m_busy ? {1'b1, m_data} : '0;
  endfunction

  task automatic model_edge();
    int w;
    m_drop = 1'b0;
    if (reset) begin
      m_last = 2; m_busy = 1'b0; m_data = '0; m_id = 2'd0; m_wire = 0;
      m_rt = 0; m_dt = 0;
    end else begin
      if (resend && m_busy && m_rt < 65535) m_rt++;
      if (m_busy && resend) begin
        if (m_wire >= MAXR + 1) begin
          m_busy = 1'b0; m_drop = 1'b1; m_wire = 0;
          if (m_dt < 255) m_dt++;
        end else begin
          m_wire++;
        end
      end else begin
        w = model_winner();
        if (ap_start && !resend && w >= 0) begin
          m_busy = 1'b1; m_data = req_data[w*PW +: PW]; m_id = 2'(w);
          m_last = w; m_wire = 1;
        end else begin
          m_busy = 1'b0; m_wire = 0;
        end
      end
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; ap_start = 1'b1; resend = 1'b0; req_valid = 3'b000;
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ap_start = 1'b0; resend = 1'b0; req_valid = 3'b000; req_data = '0;
    advance();
    advance();
    reset = 1'b0;
    n_checks++;
    if (dout !== '0) begin n_fail++; $display("[TB] FAIL reset_dout: got %h expected 0", dout); end
    n_checks++;
    if (grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_grant: got %0d expected 0", grant_id); end
    n_checks++;
    if (drop_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: drop_err=%b busy=%b expected 0 0", drop_err, busy);
    end
`ifdef LEAF_TX_STATS_EN
    n_checks++;
    if (resend_total !== 16'd0 || drop_total !== 8'd0) begin
      n_fail++; $display("[TB] FAIL reset_stats: got %0d %0d expected 0 0", resend_total, drop_total);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    req_data = '0;
    req_data[PW-1:0] = 48'h1234;
    req_valid = 3'b001; ap_start = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 001", req_ready); end
    advance();
    req_valid = 3'b000;
    n_checks++;
    if (dout !== 49'h1_0000_0000_1234 || grant_id !== 2'd0) begin
      n_fail++; $display("[TB] FAIL single_dout: got %h/%0d expected 1000000001234/0", dout, grant_id);
    end
    advance();
    n_checks++;
    if (dout !== '0) begin n_fail++; $display("[TB] FAIL single_clear: got %h expected 0", dout); end
  endtask

  task automatic test_round_robin();
    logic [PW-1:0] d [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d[i] = rand_payload();
      req_data[i*PW +: PW] = d[i];
    end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (req_ready !== 3'(1 << (k % 3))) begin
        n_fail++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 3'(1 << (k % 3)));
      end
      advance();
      n_checks++;
      if (grant_id !== 2'(k % 3) || busy !== 1'b1 || dout !== {1'b1, d[k % 3]}) begin
        n_fail++; $display("[TB] FAIL rr_grant[%0d]: got id=%0d busy=%b dout=%h expected id=%0d busy=1 dout=%h",
                           k, grant_id, busy, dout, k % 3, {1'b1, d[k % 3]});
      end
    end
    req_valid = 3'b000;
    advance();
  endtask

  task automatic test_resend_replay();
    logic [PW-1:0] d1;
    logic [PW-1:0] d2;
    do_reset();
    d1 = rand_payload(); d2 = rand_payload();
    req_data = '0;
    req_data[1*PW +: PW] = d1;
    req_data[2*PW +: PW] = d2;
    req_valid = 3'b010;
    advance();
    n_checks++;
    if (dout !== {1'b1, d1} || grant_id !== 2'd1) begin
      n_fail++; $display("[TB] FAIL replay_load: got %h/%0d expected %h/1", dout, grant_id, {1'b1, d1});
    end
    req_valid = 3'b100;
    for (int r = 0; r < 2; r++) begin
      resend = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 3'b000) begin n_fail++; $display("[TB] FAIL replay_ready[%0d]: got %b expected 000", r, req_ready); end
      advance();
      n_checks++;
      if (dout !== {1'b1, d1} || grant_id !== 2'd1) begin
        n_fail++; $display("[TB] FAIL replay_hold[%0d]: got %h/%0d expected %h/1", r, dout, grant_id, {1'b1, d1});
      end
    end
    resend = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b100) begin n_fail++; $display("[TB] FAIL replay_next_ready: got %b expected 100", req_ready); end
    advance();
    req_valid = 3'b000;
    n_checks++;
    if (dout !== {1'b1, d2} || grant_id !== 2'd2) begin
      n_fail++; $display("[TB] FAIL replay_no_bubble: got %h/%0d expected %h/2", dout, grant_id, {1'b1, d2});
    end
    advance();
  endtask

  task automatic test_drop();
    logic [PW-1:0] d0;
    do_reset();
    d0 = rand_payload();
    req_data = '0;
    req_data[PW-1:0] = d0;
    req_valid = 3'b001;
    advance();
    req_valid = 3'b000;
    resend = 1'b1;
    n_checks++;
    if (dout !== {1'b1, d0}) begin n_fail++; $display("[TB] FAIL drop_wire0: got %h expected %h", dout, {1'b1, d0}); end
    for (int j = 1; j <= MAXR; j++) begin
      advance();
      n_checks++;
      if (dout !== {1'b1, d0} || drop_err !== 1'b0) begin
        n_fail++; $display("[TB] FAIL drop_wire%0d: got %h err=%b expected %h err=0", j, dout, drop_err, {1'b1, d0});
      end
    end
    advance();
    n_checks++;
    if (dout !== '0 || drop_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL drop_pulse: got %h err=%b expected 0 err=1", dout, drop_err);
    end
`ifdef LEAF_TX_STATS_EN
    n_checks++;
    if (drop_total !== 8'd1 || resend_total !== 16'(MAXR + 1)) begin
      n_fail++; $display("[TB] FAIL drop_stats: got %0d %0d expected 1 %0d", drop_total, resend_total, MAXR + 1);
    end
`endif
    resend = 1'b0;
    advance();
    n_checks++;
    if (drop_err !== 1'b0 || dout !== '0) begin
      n_fail++; $display("[TB] FAIL drop_one_cycle: got err=%b dout=%h expected 0 0", drop_err, dout);
    end
  endtask

  task automatic test_ap_start();
    logic [PW-1:0] d1;
    do_reset();
    d1 = rand_payload();
    req_data = '0;
    req_data[1*PW +: PW] = d1;
    ap_start = 1'b0; req_valid = 3'b010;
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin n_fail++; $display("[TB] FAIL apstart_low_ready: got %b expected 000", req_ready); end
    advance();
    n_checks++;
    if (dout !== '0) begin n_fail++; $display("[TB] FAIL apstart_low_dout: got %h expected 0", dout); end
    ap_start = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin n_fail++; $display("[TB] FAIL apstart_high_ready: got %b expected 010", req_ready); end
    advance();
    req_valid = 3'b000;
    n_checks++;
    if (dout !== {1'b1, d1} || grant_id !== 2'd1) begin
      n_fail++; $display("[TB] FAIL apstart_dout: got %h/%0d expected %h/1", dout, grant_id, {1'b1, d1});
    end
    advance();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req_data = {rand_payload(), rand_payload(), rand_payload()};
    req_valid = 3'b100;
    advance();
    req_valid = 3'b000;
    resend = 1'b1;
    advance();
    reset = 1'b1;
    advance();
    reset = 1'b0; resend = 1'b0;
    n_checks++;
    if (dout !== '0 || grant_id !== 2'd0 || drop_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midhold_reset: got %h/%0d err=%b expected 0/0 err=0", dout, grant_id, drop_err);
    end
    req_valid = 3'b111;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin n_fail++; $display("[TB] FAIL midhold_ready: got %b expected 001", req_ready); end
    advance();
    req_valid = 3'b000;
    n_checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midhold_first_grant: got %0d busy=%b expected 0 busy=1", grant_id, busy);
    end
    advance();
  endtask

  task automatic test_random();
    int burst;
    burst = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) req_data[i*PW +: PW] = rand_payload();
      ap_start = ($urandom_range(0, 7) != 0);
      if (burst > 0) begin
        resend = 1'b1; burst--;
      end else begin
        resend = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 39) == 0) burst = MAXR + 2;
      end
      #1;
      n_checks++;
      if (req_ready !== model_ready()) begin
        n_fail++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, model_ready());
      end
      advance();
      n_checks++;
      if (dout !== model_dout() || busy !== m_busy) begin
        n_fail++; $display("[TB] FAIL rand_dout[%0d]: got %h busy=%b expected %h busy=%b", c, dout, busy, model_dout(), m_busy);
      end
      if (m_busy) begin
        n_checks++;
        if (grant_id !== m_id) begin
          n_fail++; $display("[TB] FAIL rand_grant[%0d]: got %0d expected %0d", c, grant_id, m_id);
        end
      end
      n_checks++;
      if (drop_err !== m_drop) begin
        n_fail++; $display("[TB] FAIL rand_drop[%0d]: got %b expected %b", c, drop_err, m_drop);
      end
`ifdef LEAF_TX_STATS_EN
      n_checks++;
      if (resend_total !== 16'(m_rt) || drop_total !== 8'(m_dt)) begin
        n_fail++; $display("[TB] FAIL rand_stats[%0d]: got %0d %0d expected %0d %0d", c, resend_total, drop_total, m_rt, m_dt);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; ap_start = 1'b0; resend = 1'b0; req_valid = 3'b000; req_data = '0;
    m_last = 2; m_busy = 1'b0; m_data = '0; m_id = 2'd0; m_wire = 0; m_drop = 1'b0;
    m_rt = 0; m_dt = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_resend_replay();
    test_drop();
    test_ap_start();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
